// File: rtl/uart_sys_pkg.sv
// rtl/uart_sys_pkg.sv - shared opcodes, sequencer state encoding and ALU function width
package uart_sys_pkg;

    localparam int ALU_FUN_W = 4;

    localparam logic [7:0] OPC_REG_WR  = 8'hAA;
    localparam logic [7:0] OPC_REG_RD  = 8'hBB;
    localparam logic [7:0] OPC_ALU_OP  = 8'hCC;
    localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_RD_SEND,
        ST_ALU_A,
        ST_ALU_B,
        ST_ALU_FUN,
        ST_ALU_WAIT,
        ST_SEND_LO,
        ST_SEND_HI
    } state_t;

    function automatic logic is_wait_state(input state_t s);
        return (s == ST_RD_WAIT) || (s == ST_ALU_WAIT);
    endfunction

endpackage

// File: rtl/uart_cmd_sequencer_if.sv
// rtl/uart_cmd_sequencer_if.sv - bundle of the sequencer's RX, register-file, ALU and TX signals
interface uart_cmd_sequencer_if
    import uart_sys_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0]   RX_P_DATA;
    logic                    RX_D_VLD;
    logic                    RF_WrEn;
    logic                    RF_RdEn;
    logic [ADDR_WIDTH-1:0]   RF_Address;
    logic [DATA_WIDTH-1:0]   RF_WrData;
    logic [DATA_WIDTH-1:0]   RF_RdData;
    logic                    RF_RdData_Valid;
    logic                    ALU_EN;
    logic [ALU_FUN_W-1:0]    ALU_FUN;
    logic [2*DATA_WIDTH-1:0] ALU_OUT;
    logic                    ALU_OUT_Valid;
    logic                    CLK_GATE_EN;
    logic [DATA_WIDTH-1:0]   TX_P_DATA;
    logic                    TX_D_VLD;
    logic                    FIFO_FULL;
    logic                    CMD_ERR;

    modport master (
        input  RX_P_DATA, RX_D_VLD, RF_RdData, RF_RdData_Valid, ALU_OUT, ALU_OUT_Valid, FIFO_FULL,
        output RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN, CLK_GATE_EN,
               TX_P_DATA, TX_D_VLD, CMD_ERR
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, RF_RdData, RF_RdData_Valid, ALU_OUT, ALU_OUT_Valid, FIFO_FULL,
        input  RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN, CLK_GATE_EN,
               TX_P_DATA, TX_D_VLD, CMD_ERR
    );
endinterface

// File: rtl/seq_timeout_cnt.sv
// rtl/seq_timeout_cnt.sv - response-wait cycle counter; expired marks the TIMEOUT-th waiting cycle
module seq_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q, count_d;

    assign expired_o = en_i && (count_q == CW'(TIMEOUT - 1));

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && !expired_o) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/uart_cmd_sequencer.sv
// rtl/uart_cmd_sequencer.sv - decodes UART command frames into register-file, ALU and TX transactions
module uart_cmd_sequencer
    import uart_sys_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    output logic                    RF_WrEn,
    output logic                    RF_RdEn,
    output logic [ADDR_WIDTH-1:0]   RF_Address,
    output logic [DATA_WIDTH-1:0]   RF_WrData,
    input  logic [DATA_WIDTH-1:0]   RF_RdData,
    input  logic                    RF_RdData_Valid,
    output logic                    ALU_EN,
    output logic [ALU_FUN_W-1:0]    ALU_FUN,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_Valid,
    output logic                    CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD,
    input  logic                    FIFO_FULL,
    output logic                    CMD_ERR
);
    state_t                  state_q, state_d;
    logic                    wr_en_q, wr_en_d, rd_en_q, rd_en_d, alu_en_q, alu_en_d;
    logic                    tx_vld_q, tx_vld_d, err_q, err_d, gate_q, gate_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, tx_data_q, tx_data_d, alu_hi_q, alu_hi_d;
    logic [ALU_FUN_W-1:0]    fun_q, fun_d;
    logic                    expired;

    seq_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .CLK       (CLK),
        .RST       (RST),
        .clear_i   (!is_wait_state(state_q)),
        .en_i      (is_wait_state(state_q)),
        .expired_o (expired)
    );

    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        alu_en_d  = 1'b0;
        tx_vld_d  = 1'b0;
        err_d     = 1'b0;
        gate_d    = gate_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        tx_data_d = tx_data_q;
        alu_hi_d  = alu_hi_q;
        fun_d     = fun_q;

        // Bytes arriving while a response or TX is pending are dropped and flagged.
        if (RX_D_VLD && (is_wait_state(state_q) || state_q == ST_RD_SEND ||
                         state_q == ST_SEND_LO || state_q == ST_SEND_HI)) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: if (RX_D_VLD) begin
                case (RX_P_DATA)
                    DATA_WIDTH'(OPC_REG_WR):  state_d = ST_WR_ADDR;
                    DATA_WIDTH'(OPC_REG_RD):  state_d = ST_RD_ADDR;
                    DATA_WIDTH'(OPC_ALU_OP):  state_d = ST_ALU_A;
                    DATA_WIDTH'(OPC_ALU_NOP): state_d = ST_ALU_FUN;
                    default:                  err_d   = 1'b1;
                endcase
            end
            ST_WR_ADDR: if (RX_D_VLD) begin
                addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                state_d = ST_WR_DATA;
            end
            ST_WR_DATA: if (RX_D_VLD) begin
                wr_en_d = 1'b1;
                wdata_d = RX_P_DATA;
                state_d = ST_IDLE;
            end
            ST_RD_ADDR: if (RX_D_VLD) begin
                addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                rd_en_d = 1'b1;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (RF_RdData_Valid) begin
                    tx_data_d = RF_RdData;
                    state_d   = ST_RD_SEND;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_RD_SEND: if (!FIFO_FULL) begin
                tx_vld_d = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_ALU_A: if (RX_D_VLD) begin
                addr_d  = '0;
                wdata_d = RX_P_DATA;
                wr_en_d = 1'b1;
                state_d = ST_ALU_B;
            end
            ST_ALU_B: if (RX_D_VLD) begin
                addr_d  = ADDR_WIDTH'(1);
                wdata_d = RX_P_DATA;
                wr_en_d = 1'b1;
                state_d = ST_ALU_FUN;
            end
            ST_ALU_FUN: if (RX_D_VLD) begin
                fun_d    = RX_P_DATA[ALU_FUN_W-1:0];
                alu_en_d = 1'b1;
                gate_d   = 1'b1;
                state_d  = ST_ALU_WAIT;
            end
            ST_ALU_WAIT: begin
                if (ALU_OUT_Valid) begin
                    tx_data_d = ALU_OUT[DATA_WIDTH-1:0];
                    alu_hi_d  = ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
                    gate_d    = 1'b0;
                    state_d   = ST_SEND_LO;
                end else if (expired) begin
                    err_d   = 1'b1;
                    gate_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_SEND_LO: if (!FIFO_FULL) begin
                tx_vld_d = 1'b1;
                state_d  = ST_SEND_HI;
            end
            // Low byte leaves TX_P_DATA on the edge entering here, so the upper byte loads now.
            ST_SEND_HI: begin
                tx_data_d = alu_hi_q;
                if (!FIFO_FULL) begin
                    tx_vld_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            alu_en_q  <= 1'b0;
            tx_vld_q  <= 1'b0;
            err_q     <= 1'b0;
            gate_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            tx_data_q <= '0;
            alu_hi_q  <= '0;
            fun_q     <= '0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            alu_en_q  <= alu_en_d;
            tx_vld_q  <= tx_vld_d;
            err_q     <= err_d;
            gate_q    <= gate_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            tx_data_q <= tx_data_d;
            alu_hi_q  <= alu_hi_d;
            fun_q     <= fun_d;
        end
    end

    assign RF_WrEn     = wr_en_q;
    assign RF_RdEn     = rd_en_q;
    assign RF_Address  = addr_q;
    assign RF_WrData   = wdata_q;
    assign ALU_EN      = alu_en_q;
    assign ALU_FUN     = fun_q;
    assign CLK_GATE_EN = gate_q;
    assign TX_P_DATA   = tx_data_q;
    assign TX_D_VLD    = tx_vld_q;
    assign CMD_ERR     = err_q;
endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb/tb_uart_cmd_sequencer.sv - directed self-checking bench for uart_cmd_sequencer
module tb_uart_cmd_sequencer;
    import uart_sys_pkg::*;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int TO = 16;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    uart_cmd_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    uart_cmd_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .RX_P_DATA       (bus.RX_P_DATA),
        .RX_D_VLD        (bus.RX_D_VLD),
        .RF_WrEn         (bus.RF_WrEn),
        .RF_RdEn         (bus.RF_RdEn),
        .RF_Address      (bus.RF_Address),
        .RF_WrData       (bus.RF_WrData),
        .RF_RdData       (bus.RF_RdData),
        .RF_RdData_Valid (bus.RF_RdData_Valid),
        .ALU_EN          (bus.ALU_EN),
        .ALU_FUN         (bus.ALU_FUN),
        .ALU_OUT         (bus.ALU_OUT),
        .ALU_OUT_Valid   (bus.ALU_OUT_Valid),
        .CLK_GATE_EN     (bus.CLK_GATE_EN),
        .TX_P_DATA       (bus.TX_P_DATA),
        .TX_D_VLD        (bus.TX_D_VLD),
        .FIFO_FULL       (bus.FIFO_FULL),
        .CMD_ERR         (bus.CMD_ERR)
    );

    int checks = 0;
    int failures = 0;

    // Strobe monitor, sampled just after each active edge.
    int rd_n = 0, alu_n = 0, err_n = 0, full_viol = 0;
    logic [AW+DW-1:0] wr_log[$];
    logic [DW-1:0]    tx_log[$];

    always @(posedge CLK) begin
        #1;
        if (bus.RF_WrEn)  wr_log.push_back({bus.RF_Address, bus.RF_WrData});
        if (bus.RF_RdEn)  rd_n++;
        if (bus.ALU_EN)   alu_n++;
        if (bus.CMD_ERR)  err_n++;
        if (bus.TX_D_VLD) begin
            tx_log.push_back(bus.TX_P_DATA);
            if (bus.FIFO_FULL) full_viol++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        bus.RX_P_DATA = b;
        bus.RX_D_VLD  = 1'b1;
        @(negedge CLK);
        bus.RX_D_VLD  = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.RX_P_DATA = '0; bus.RX_D_VLD = 1'b0;
        bus.RF_RdData = '0; bus.RF_RdData_Valid = 1'b0;
        bus.ALU_OUT = '0;   bus.ALU_OUT_Valid = 1'b0;
        bus.FIFO_FULL = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({bus.RF_WrEn, bus.RF_RdEn, bus.ALU_EN, bus.TX_D_VLD, bus.CMD_ERR, bus.CLK_GATE_EN} !== 6'b0) begin
            failures++;
            $display("FAIL reset_strobes: got %b expected 000000",
                     {bus.RF_WrEn, bus.RF_RdEn, bus.ALU_EN, bus.TX_D_VLD, bus.CMD_ERR, bus.CLK_GATE_EN});
        end
        checks++;
        if (bus.RF_Address !== 4'h0 || bus.RF_WrData !== 8'h00) begin
            failures++;
            $display("FAIL reset_rf: got addr=%h data=%h expected 0/00", bus.RF_Address, bus.RF_WrData);
        end
        checks++;
        if (bus.ALU_FUN !== 4'h0 || bus.TX_P_DATA !== 8'h00) begin
            failures++;
            $display("FAIL reset_alu_tx: got fun=%h tx=%h expected 0/00", bus.ALU_FUN, bus.TX_P_DATA);
        end
        checks++;
        if (dut.state_q !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_state: got %0d expected %0d", dut.state_q, ST_IDLE);
        end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reg_write();
        wr_log.delete();
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        repeat (3) @(negedge CLK);
        checks++;
        if (wr_log.size() !== 1) begin
            failures++;
            $display("FAIL wr_count: got %0d expected 1", wr_log.size());
        end else begin
            checks++;
            if (wr_log[0] !== 12'h53C) begin
                failures++;
                $display("FAIL wr_addr_data: got %h expected 53c", wr_log[0]);
            end
        end
        checks++;
        if (dut.state_q !== ST_IDLE) begin
            failures++;
            $display("FAIL wr_idle: got %0d expected %0d", dut.state_q, ST_IDLE);
        end
    endtask

    task automatic test_reg_read();
        int rd0;
        rd0 = rd_n;
        tx_log.delete();
        send_byte(8'hBB); send_byte(8'h07);
        repeat (3) @(negedge CLK);
        bus.RF_RdData = 8'h5A; bus.RF_RdData_Valid = 1'b1;
        @(negedge CLK);
        bus.RF_RdData_Valid = 1'b0; bus.RF_RdData = 8'h00;
        repeat (4) @(negedge CLK);
        checks++;
        if (rd_n - rd0 !== 1) begin
            failures++;
            $display("FAIL rd_en_count: got %0d expected 1", rd_n - rd0);
        end
        checks++;
        if (tx_log.size() !== 1 || tx_log[0] !== 8'h5A) begin
            failures++;
            $display("FAIL rd_tx: got n=%0d byte=%h expected 1/5a", tx_log.size(), tx_log[0]);
        end
    endtask

    task automatic test_alu_operands();
        int alu0;
        alu0 = alu_n;
        wr_log.delete(); tx_log.delete();
        send_byte(8'hCC); send_byte(8'h10); send_byte(8'h20); send_byte(8'h00);
        checks++;
        if (bus.ALU_EN !== 1'b1 || bus.ALU_FUN !== 4'h0 || bus.CLK_GATE_EN !== 1'b1) begin
            failures++;
            $display("FAIL alu_start: got en=%b fun=%h gate=%b expected 1/0/1", bus.ALU_EN, bus.ALU_FUN, bus.CLK_GATE_EN);
        end
        repeat (2) @(negedge CLK);
        bus.ALU_OUT = 16'h0030; bus.ALU_OUT_Valid = 1'b1;
        @(negedge CLK);
        bus.ALU_OUT_Valid = 1'b0; bus.ALU_OUT = '0;
        repeat (6) @(negedge CLK);
        checks++;
        if (wr_log.size() !== 2 || wr_log[0] !== 12'h010 || wr_log[1] !== 12'h120) begin
            failures++;
            $display("FAIL alu_operand_writes: got n=%0d %h %h expected 2 010 120", wr_log.size(), wr_log[0], wr_log[1]);
        end
        checks++;
        if (tx_log.size() !== 2 || tx_log[0] !== 8'h30 || tx_log[1] !== 8'h00) begin
            failures++;
            $display("FAIL alu_tx: got n=%0d %h %h expected 2 30 00", tx_log.size(), tx_log[0], tx_log[1]);
        end
        checks++;
        if (alu_n - alu0 !== 1 || bus.CLK_GATE_EN !== 1'b0) begin
            failures++;
            $display("FAIL alu_en_gate: got en_n=%0d gate=%b expected 1/0", alu_n - alu0, bus.CLK_GATE_EN);
        end
    endtask

    task automatic test_fifo_full();
        int viol0;
        viol0 = full_viol;
        tx_log.delete();
        bus.FIFO_FULL = 1'b1;
        send_byte(8'hDD); send_byte(8'h02);
        checks++;
        if (bus.ALU_EN !== 1'b1 || bus.ALU_FUN !== 4'h2) begin
            failures++;
            $display("FAIL nop_alu_start: got en=%b fun=%h expected 1/2", bus.ALU_EN, bus.ALU_FUN);
        end
        @(negedge CLK);
        bus.ALU_OUT = 16'hBEEF; bus.ALU_OUT_Valid = 1'b1;
        @(negedge CLK);
        bus.ALU_OUT_Valid = 1'b0; bus.ALU_OUT = '0;
        repeat (5) @(negedge CLK);
        checks++;
        if (tx_log.size() !== 0) begin
            failures++;
            $display("FAIL tx_while_full: got %0d bytes expected 0", tx_log.size());
        end
        bus.FIFO_FULL = 1'b0;
        repeat (6) @(negedge CLK);
        checks++;
        if (tx_log.size() !== 2 || tx_log[0] !== 8'hEF || tx_log[1] !== 8'hBE || full_viol - viol0 !== 0) begin
            failures++;
            $display("FAIL tx_after_release: got n=%0d %h %h viol=%0d expected 2 ef be 0",
                     tx_log.size(), tx_log[0], tx_log[1], full_viol - viol0);
        end
    endtask

    task automatic test_timeout();
        int n;
        int err0;
        n = 0;
        err0 = err_n;
        tx_log.delete();
        send_byte(8'hBB); send_byte(8'h03);
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (bus.CMD_ERR === 1'b1) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n !== TO) begin
            failures++;
            $display("FAIL timeout_latency: got %0d cycles expected %0d", n, TO);
        end
        repeat (3) @(negedge CLK);
        checks++;
        if (tx_log.size() !== 0 || dut.state_q !== ST_IDLE || err_n - err0 !== 1) begin
            failures++;
            $display("FAIL timeout_after: got tx=%0d state=%0d err=%0d expected 0/%0d/1",
                     tx_log.size(), dut.state_q, err_n - err0, ST_IDLE);
        end
    endtask

    task automatic test_bad_cmd();
        int rd0, alu0, err0;
        rd0 = rd_n; alu0 = alu_n; err0 = err_n;
        wr_log.delete(); tx_log.delete();
        send_byte(8'h77);
        checks++;
        if (bus.CMD_ERR !== 1'b1) begin
            failures++;
            $display("FAIL bad_cmd_err: got %b expected 1", bus.CMD_ERR);
        end
        repeat (3) @(negedge CLK);
        checks++;
        if (wr_log.size() + tx_log.size() + (rd_n - rd0) + (alu_n - alu0) !== 0 || err_n - err0 !== 1) begin
            failures++;
            $display("FAIL bad_cmd_strobes: got strobes=%0d err=%0d expected 0/1",
                     wr_log.size() + tx_log.size() + (rd_n - rd0) + (alu_n - alu0), err_n - err0);
        end
    endtask

    task automatic test_drop_in_wait();
        tx_log.delete();
        send_byte(8'hBB); send_byte(8'h09);
        send_byte(8'h11);
        checks++;
        if (bus.CMD_ERR !== 1'b1 || dut.state_q !== ST_RD_WAIT) begin
            failures++;
            $display("FAIL drop_in_wait: got err=%b state=%0d expected 1/%0d", bus.CMD_ERR, dut.state_q, ST_RD_WAIT);
        end
        bus.RF_RdData = 8'h44; bus.RF_RdData_Valid = 1'b1;
        @(negedge CLK);
        bus.RF_RdData_Valid = 1'b0; bus.RF_RdData = 8'h00;
        repeat (4) @(negedge CLK);
        checks++;
        if (tx_log.size() !== 1 || tx_log[0] !== 8'h44) begin
            failures++;
            $display("FAIL drop_then_read: got n=%0d byte=%h expected 1/44", tx_log.size(), tx_log[0]);
        end
    endtask

    task automatic test_reset_mid_frame();
        wr_log.delete();
        send_byte(8'hAA); send_byte(8'h05);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checks++;
        if (dut.state_q !== ST_IDLE) begin
            failures++;
            $display("FAIL rst_mid_state: got %0d expected %0d", dut.state_q, ST_IDLE);
        end
        send_byte(8'h3C);
        repeat (3) @(negedge CLK);
        checks++;
        if (wr_log.size() !== 0) begin
            failures++;
            $display("FAIL rst_mid_write: got %0d writes expected 0", wr_log.size());
        end
    endtask

    initial begin
        test_reset();
        test_reg_write();
        test_reg_read();
        test_alu_operands();
        test_fifo_full();
        test_timeout();
        test_bad_cmd();
        test_drop_in_wait();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
